bram_responder: RTL and testbench
=================================

Name: bram_responder

Overview:
- Cycle-accurate dual-port synchronous BRAM model for the memory side of the two-port BRAM interface that the load/store-to-BRAM converters drive (ce/we/address/dout out, din in).
- Serves both ports with a configurable read latency.
- Clears its contents after reset and detects write collisions.
- Exposes a low-priority valid/ready host channel for preload and dump from benches or a debug controller.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, address width.
- DEPTH, 16, number of words; must be ≤ 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from ce to din valid; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- ce0  in  1  port 0 enable.
- we0  in  1  port 0 write enable; qualified by ce0.
- address0  in  ADDR_WIDTH  port 0 address.
- dout0  in  DATA_WIDTH  port 0 write data (converter's dout0).
- din0  out  DATA_WIDTH  port 0 read data.
- ce1, we1, address1, dout1, din1: same as port 0, for port 1.
- host_valid  in  1  host request valid.
- host_ready  out  1  host request accepted.
- host_we  in  1  1 = host write, 0 = host read.
- host_addr  in  ADDR_WIDTH  host address.
- host_wdata  in  DATA_WIDTH  host write data.
- host_rdata  out  DATA_WIDTH  host read data.
- host_rvalid  out  1  host read data valid; single-cycle pulse.
- init_done  out  1  post-reset clear finished.
- collision  out  1  sticky: same-address write/write or out-of-range access seen.

Behaviour:
- Reset: rst=0 sampled at a rising edge. Next cycle: din0 = din1 = host_rdata = 0; host_rvalid = 0; init_done = 0; collision = 0; host_ready = 0; read pipelines flushed; FSM enters CLEAR with clear counter = 0.
- Reset mid-operation (including mid-CLEAR or with reads in flight): same as above. In-flight reads are dropped and CLEAR restarts from address 0.
- FSM states are CLEAR and IDLE.
  - CLEAR: writes 0 to address = counter each cycle. Counter runs 0..DEPTH-1, then moves to IDLE. init_done rises the cycle after the last clear write, so it is 1 exactly DEPTH cycles after the first non-reset edge.
  - In CLEAR, ce0/ce1/host_valid are ignored: no writes, no reads issued, din outputs hold 0.
- IDLE port access: each port independently acts when ceN=1.
  - weN=1: mem[addressN] <= doutN at the edge.
  - weN=0: read issued; dinN shows mem[addressN] exactly READ_LATENCY cycles later.
  - dinN holds its last read value when no read retires.
- Read-first: a read and a write to the same address in the same cycle, on the same or the other port, return the old data.
- Write/write same address same cycle: port 1 data wins and collision is set.
- Out-of-range address (≥ DEPTH) on a port with ce=1: write is dropped, read returns 0, collision is set.
- collision clears only on reset.
- Host channel:
  - host_ready = (state==IDLE) && !ce0 && !ce1, computed combinationally. Ports always have priority.
  - A transfer happens when host_valid && host_ready.
  - Host write updates mem at that edge.
  - Host read gives host_rdata and a 1-cycle host_rvalid pulse READ_LATENCY cycles later; host_rdata holds between pulses.
  - Host out-of-range access: write dropped, read data 0, collision is set.
- Back-to-back reads on every port and the host are fully pipelined, one per cycle.
- All outputs are registered except host_ready.

Decomposition:
- Shared package: localparam MAX_READ_LATENCY = 4; state enum bram_state_t {CLEAR, IDLE}; a function addr_in_range(addr, depth).
- One sub-module: bram_read_pipe, a parameterised READ_LATENCY-deep valid+data shift register. Three instances: port 0, port 1, host.

Test Plan:
- Post-reset clear: DEPTH=16, rst low 2 cycles then high → init_done=1 exactly 16 cycles later; host reads of addresses 0..15 return 0; collision=0.
- Port round-trip, READ_LATENCY=2: port 0 writes 0xA5 to addr 3; next cycle port 1 reads addr 3 → din1=0xA5 two cycles after the read; din0 stays 0.
- Read-first and collision: port 0 reads addr 5 (value 0x11) while port 1 writes 0x22 to addr 5 → din0=0x11, then a later read gives 0x22. Both ports write addr 7 (0x33/0x44) → mem[7]=0x44, collision=1.
- Host priority: host_valid=1 with ce0 toggling 1,0,1,0 → host_ready=0 whenever ce0=1; host write of 0x5A to addr 9 lands only in a ce-free cycle; a port read of addr 9 later returns 0x5A.
- Out of range, DEPTH=12: port 0 writes addr 13 → no array change, collision=1; a read of addr 13 returns 0.
- Reset mid-operation: three reads in flight and CLEAR counter at 8 when rst pulses low → no din update from the dropped reads; init_done=0, rising 16 cycles after rst returns high; memory all zero.

Source files
------------

// File: rtl/bram_responder_pkg.sv
// Shared types and helpers for the BRAM responder.
// Pure declarations: no latency, no flow control.
package bram_responder_pkg;

   localparam int MAX_READ_LATENCY = 4;

   typedef enum logic {
      CLEAR,
      IDLE
   } bram_state_t;

   function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/bram_responder_if.sv
// Two-port BRAM bus plus host preload/dump channel.
// master = converter/bench side, slave = memory side.
interface bram_responder_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  ce0;
   logic                  we0;
   logic [ADDR_WIDTH-1:0] address0;
   logic [DATA_WIDTH-1:0] dout0;
   logic [DATA_WIDTH-1:0] din0;
   logic                  ce1;
   logic                  we1;
   logic [ADDR_WIDTH-1:0] address1;
   logic [DATA_WIDTH-1:0] dout1;
   logic [DATA_WIDTH-1:0] din1;
   logic                  host_valid;
   logic                  host_ready;
   logic                  host_we;
   logic [ADDR_WIDTH-1:0] host_addr;
   logic [DATA_WIDTH-1:0] host_wdata;
   logic [DATA_WIDTH-1:0] host_rdata;
   logic                  host_rvalid;
   logic                  init_done;
   logic                  collision;

   modport master (
      output ce0, we0, address0, dout0,
      output ce1, we1, address1, dout1,
      output host_valid, host_we, host_addr, host_wdata,
      input  din0, din1, host_ready, host_rdata, host_rvalid, init_done, collision
   );

   modport slave (
      input  ce0, we0, address0, dout0,
      input  ce1, we1, address1, dout1,
      input  host_valid, host_we, host_addr, host_wdata,
      output din0, din1, host_ready, host_rdata, host_rvalid, init_done, collision
   );
endinterface

// File: rtl/bram_read_pipe.sv
// READ_LATENCY-deep valid+data shift register; last stage holds data between valid beats.
// Latency READ_LATENCY counting the issue edge; no backpressure, accepts one read per cycle.
module bram_read_pipe #(
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_vld,
   input  logic [DATA_WIDTH-1:0] in_dat,
   output logic                  out_vld,
   output logic [DATA_WIDTH-1:0] out_dat
);
   logic [READ_LATENCY-1:0] vld_q;
   logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q <= '0;
         for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
      end else begin
         vld_q[0] <= in_vld;
         if (in_vld || READ_LATENCY > 1) dat_q[0] <= in_dat;
         // The final stage only loads on a retiring read so the output holds.
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1] || i < READ_LATENCY - 1) dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign out_vld = vld_q[READ_LATENCY-1];
   assign out_dat = dat_q[READ_LATENCY-1];
endmodule

// File: rtl/bram_responder.sv
// Dual-port synchronous BRAM model with post-reset clear, sticky collision flag and host port.
// Reads retire READ_LATENCY cycles after issue; host_ready drops whenever either port is enabled.
module bram_responder
   import bram_responder_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 4,
   parameter int DEPTH        = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   bram_responder_if.slave  bus
);
   localparam int WORDS = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [WORDS];
   bram_state_t           state;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  init_done_q;
   logic                  collision_q;

   logic idle, p0_ok, p1_ok, h_ok;
   logic p0_wr, p1_wr, p0_rd, p1_rd, h_xfer, h_wr, h_rd;
   logic ww_same, coll_evt;
   logic [DATA_WIDTH-1:0] p0_rdat, p1_rdat, h_rdat;
   logic p0_vld, p1_vld, unused_port_vld;

   assign idle  = (state == IDLE);
   assign p0_ok = addr_in_range(32'(bus.address0), DEPTH);
   assign p1_ok = addr_in_range(32'(bus.address1), DEPTH);
   assign h_ok  = addr_in_range(32'(bus.host_addr), DEPTH);

   assign p0_wr  = idle && bus.ce0 && bus.we0 && p0_ok;
   assign p1_wr  = idle && bus.ce1 && bus.we1 && p1_ok;
   assign p0_rd  = idle && bus.ce0 && !bus.we0;
   assign p1_rd  = idle && bus.ce1 && !bus.we1;

   assign bus.host_ready = idle && !bus.ce0 && !bus.ce1;
   assign h_xfer = bus.host_valid && bus.host_ready;
   assign h_wr   = h_xfer && bus.host_we && h_ok;
   assign h_rd   = h_xfer && !bus.host_we;

   // Array reads happen before the edge's writes land, giving read-first behaviour.
   assign p0_rdat = p0_ok ? mem[bus.address0] : '0;
   assign p1_rdat = p1_ok ? mem[bus.address1] : '0;
   assign h_rdat  = h_ok  ? mem[bus.host_addr] : '0;

   assign ww_same  = p0_wr && p1_wr && (bus.address0 == bus.address1);
   assign coll_evt = idle && (ww_same || (bus.ce0 && !p0_ok) || (bus.ce1 && !p1_ok)
                                      || (h_xfer && !h_ok));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= CLEAR;
         clr_cnt     <= '0;
         init_done_q <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         if (coll_evt) collision_q <= 1'b1;
         case (state)
            CLEAR: begin
               if (32'(clr_cnt) == DEPTH - 1) begin
                  state       <= IDLE;
                  init_done_q <= 1'b1;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Port 1 is written after port 0 so it wins a same-address write/write.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (!idle) begin
            mem[clr_cnt] <= '0;
         end else begin
            if (p0_wr) mem[bus.address0]  <= bus.dout0;
            if (p1_wr) mem[bus.address1]  <= bus.dout1;
            if (h_wr)  mem[bus.host_addr] <= bus.host_wdata;
         end
      end
   end

   bram_read_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe0 (
      .clk(clk), .rst(rst), .in_vld(p0_rd), .in_dat(p0_rdat),
      .out_vld(p0_vld), .out_dat(bus.din0)
   );

   bram_read_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe1 (
      .clk(clk), .rst(rst), .in_vld(p1_rd), .in_dat(p1_rdat),
      .out_vld(p1_vld), .out_dat(bus.din1)
   );

   bram_read_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe_host (
      .clk(clk), .rst(rst), .in_vld(h_rd), .in_dat(h_rdat),
      .out_vld(bus.host_rvalid), .out_dat(bus.host_rdata)
   );

   assign unused_port_vld = p0_vld ^ p1_vld;
   assign bus.init_done   = init_done_q;
   assign bus.collision   = collision_q;
endmodule

// File: tb/tb_bram_responder.sv
// Directed bench: main instance DEPTH=16/READ_LATENCY=2, second instance DEPTH=12/READ_LATENCY=1.
module tb_bram_responder;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   bram_responder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ia ();
   bram_responder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ob ();

   bram_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(2)) dut (
      .clk(clk), .rst(rst), .bus(ia)
   );
   bram_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .READ_LATENCY(1)) dut_o (
      .clk(clk), .rst(rst), .bus(ob)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      int ce0, we0, a0, d0;
      int ce1, we1, a1, d1;
      int e_din0, e_din1, e_coll;
   } vec_t;
   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all;
      ia.ce0 = 0; ia.we0 = 0; ia.address0 = '0; ia.dout0 = '0;
      ia.ce1 = 0; ia.we1 = 0; ia.address1 = '0; ia.dout1 = '0;
      ia.host_valid = 0; ia.host_we = 0; ia.host_addr = '0; ia.host_wdata = '0;
      ob.ce0 = 0; ob.we0 = 0; ob.address0 = '0; ob.dout0 = '0;
      ob.ce1 = 0; ob.we1 = 0; ob.address1 = '0; ob.dout1 = '0;
      ob.host_valid = 0; ob.host_we = 0; ob.host_addr = '0; ob.host_wdata = '0;
   endtask

   function automatic vec_t mk(int ce0, int we0, int a0, int d0, int ce1, int we1, int a1, int d1,
                               int e0, int e1, int ec);
      vec_t v;
      v.ce0 = ce0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
      v.ce1 = ce1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
      v.e_din0 = e0; v.e_din1 = e1; v.e_coll = ec;
      return v;
   endfunction

   // Back-to-back host reads of every word of the main instance, all expected zero.
   task automatic dump_zero(input string tag);
      for (int j = 0; j <= 16; j++) begin
         if (j < 16) begin
            ia.host_valid = 1; ia.host_we = 0; ia.host_addr = 4'(j);
         end else begin
            ia.host_valid = 0;
         end
         tick;
         if (j >= 1) begin
            chk($sformatf("%s rvalid[%0d]", tag, j - 1), 32'(ia.host_rvalid), 32'd1);
            chk($sformatf("%s rdata[%0d]", tag, j - 1), 32'(ia.host_rdata), 32'd0);
         end
      end
      tick;
      chk($sformatf("%s rvalid end", tag), 32'(ia.host_rvalid), 32'd0);
   endtask

   initial begin
      //            ce0 we0 a0 d0      ce1 we1 a1 d1      din0   din1   coll
      vecs[0]  = mk(1, 1, 3, 'hA5,  0, 0, 0, 0,       'h00, 'h00, 0);
      vecs[1]  = mk(0, 0, 0, 0,     1, 0, 3, 0,       'h00, 'h00, 0);
      vecs[2]  = mk(0, 0, 0, 0,     0, 0, 0, 0,       'h00, 'hA5, 0);
      vecs[3]  = mk(1, 1, 5, 'h11,  0, 0, 0, 0,       'h00, 'hA5, 0);
      vecs[4]  = mk(1, 0, 5, 0,     1, 1, 5, 'h22,    'h00, 'hA5, 0);
      vecs[5]  = mk(0, 0, 0, 0,     0, 0, 0, 0,       'h11, 'hA5, 0);
      vecs[6]  = mk(1, 0, 5, 0,     0, 0, 0, 0,       'h11, 'hA5, 0);
      vecs[7]  = mk(0, 0, 0, 0,     0, 0, 0, 0,       'h22, 'hA5, 0);
      vecs[8]  = mk(1, 1, 7, 'h33,  1, 1, 7, 'h44,    'h22, 'hA5, 1);
      vecs[9]  = mk(1, 0, 7, 0,     0, 0, 0, 0,       'h22, 'hA5, 1);
      vecs[10] = mk(1, 0, 3, 0,     1, 0, 7, 0,       'h44, 'hA5, 1);
      vecs[11] = mk(1, 0, 5, 0,     1, 0, 3, 0,       'hA5, 'h44, 1);
      vecs[12] = mk(0, 0, 0, 0,     0, 0, 0, 0,       'h22, 'hA5, 1);
      vecs[13] = mk(0, 0, 0, 0,     0, 0, 0, 0,       'h22, 'hA5, 1);

      idle_all();
      rst = 0;
      tick;
      tick;
      chk("rst din0", 32'(ia.din0), 32'd0);
      chk("rst din1", 32'(ia.din1), 32'd0);
      chk("rst host_rdata", 32'(ia.host_rdata), 32'd0);
      chk("rst host_rvalid", 32'(ia.host_rvalid), 32'd0);
      chk("rst init_done", 32'(ia.init_done), 32'd0);
      chk("rst collision", 32'(ia.collision), 32'd0);
      chk("rst host_ready", 32'(ia.host_ready), 32'd0);

      rst = 1;
      for (int c = 1; c <= 16; c++) begin
         if (c == 5) begin
            ia.host_valid = 1; ia.host_we = 1; ia.host_addr = 4'd15; ia.host_wdata = 8'hBB;
            #1;
            chk("clear host_ready", 32'(ia.host_ready), 32'd0);
         end
         if (c == 16) begin
            ia.ce0 = 1; ia.we0 = 1; ia.address0 = 4'd2; ia.dout0 = 8'hEE;
         end
         tick;
         ia.host_valid = 0;
         if (c == 15) chk("init_done @15", 32'(ia.init_done), 32'd0);
         if (c == 16) chk("init_done @16", 32'(ia.init_done), 32'd1);
         if (c == 11) chk("o init_done @11", 32'(ob.init_done), 32'd0);
         if (c == 12) chk("o init_done @12", 32'(ob.init_done), 32'd1);
      end
      idle_all();
      chk("clear din0", 32'(ia.din0), 32'd0);
      chk("clear collision", 32'(ia.collision), 32'd0);
      dump_zero("clear");

      for (int i = 0; i < 14; i++) begin
         ia.ce0 = (vecs[i].ce0 != 0); ia.we0 = (vecs[i].we0 != 0);
         ia.address0 = 4'(vecs[i].a0); ia.dout0 = 8'(vecs[i].d0);
         ia.ce1 = (vecs[i].ce1 != 0); ia.we1 = (vecs[i].we1 != 0);
         ia.address1 = 4'(vecs[i].a1); ia.dout1 = 8'(vecs[i].d1);
         tick;
         chk($sformatf("v%0d din0", i), 32'(ia.din0), 32'(vecs[i].e_din0));
         chk($sformatf("v%0d din1", i), 32'(ia.din1), 32'(vecs[i].e_din1));
         chk($sformatf("v%0d coll", i), 32'(ia.collision), 32'(vecs[i].e_coll));
      end
      idle_all();

      // Host priority: host write to 9 pending while ce0 toggles 1,0,1,0.
      ia.host_valid = 1; ia.host_we = 1; ia.host_addr = 4'd9; ia.host_wdata = 8'h5A;
      ia.ce0 = 1; ia.we0 = 0; ia.address0 = 4'd9;
      #1;
      chk("prio ready ce=1 a", 32'(ia.host_ready), 32'd0);
      tick;
      ia.ce0 = 0;
      #1;
      chk("prio ready ce=0 a", 32'(ia.host_ready), 32'd1);
      tick;
      chk("prio old din0", 32'(ia.din0), 32'd0);
      ia.host_valid = 0;
      ia.ce0 = 1; ia.address0 = 4'd9;
      #1;
      chk("prio ready ce=1 b", 32'(ia.host_ready), 32'd0);
      tick;
      ia.ce0 = 0;
      #1;
      chk("prio ready ce=0 b", 32'(ia.host_ready), 32'd1);
      tick;
      chk("prio new din0", 32'(ia.din0), 32'h5A);
      ia.host_valid = 1; ia.host_we = 0; ia.host_addr = 4'd9;
      tick;
      ia.host_valid = 0;
      chk("hrd rvalid early", 32'(ia.host_rvalid), 32'd0);
      tick;
      chk("hrd rvalid", 32'(ia.host_rvalid), 32'd1);
      chk("hrd rdata", 32'(ia.host_rdata), 32'h5A);
      tick;
      chk("hrd rvalid pulse", 32'(ia.host_rvalid), 32'd0);
      chk("hrd rdata hold", 32'(ia.host_rdata), 32'h5A);

      // Out-of-range accesses on the DEPTH=12 instance.
      ob.ce0 = 1; ob.we0 = 1; ob.address0 = 4'd2; ob.dout0 = 8'h42;
      tick;
      chk("oor coll before", 32'(ob.collision), 32'd0);
      ob.we0 = 0;
      tick;
      chk("oor rd 2", 32'(ob.din0), 32'h42);
      ob.we0 = 1; ob.address0 = 4'd13; ob.dout0 = 8'h99;
      tick;
      chk("oor coll after", 32'(ob.collision), 32'd1);
      ob.we0 = 0;
      tick;
      chk("oor rd 13", 32'(ob.din0), 32'd0);
      ob.address0 = 4'd2;
      tick;
      chk("oor rd 2 again", 32'(ob.din0), 32'h42);
      ob.address0 = 4'd1;
      tick;
      chk("oor rd 1", 32'(ob.din0), 32'd0);
      ob.ce0 = 0;
      ob.host_valid = 1; ob.host_we = 0; ob.host_addr = 4'd13;
      tick;
      chk("oor host rvalid", 32'(ob.host_rvalid), 32'd1);
      chk("oor host rdata", 32'(ob.host_rdata), 32'd0);
      ob.host_addr = 4'd2;
      tick;
      ob.host_valid = 0;
      chk("oor host rd 2", 32'(ob.host_rdata), 32'h42);

      // Reset with reads in flight on both instances.
      ia.ce0 = 1; ia.we0 = 0; ia.address0 = 4'd3;
      ia.ce1 = 1; ia.we1 = 0; ia.address1 = 4'd5;
      ob.host_valid = 1; ob.host_we = 0; ob.host_addr = 4'd1;
      tick;
      idle_all();
      rst = 0;
      tick;
      rst = 1;
      chk("mid din0", 32'(ia.din0), 32'd0);
      chk("mid din1", 32'(ia.din1), 32'd0);
      chk("mid o host_rdata", 32'(ob.host_rdata), 32'd0);
      chk("mid o host_rvalid", 32'(ob.host_rvalid), 32'd0);
      chk("mid coll", 32'(ia.collision), 32'd0);
      chk("mid o coll", 32'(ob.collision), 32'd0);
      chk("mid init_done", 32'(ia.init_done), 32'd0);
      for (int k = 1; k <= 8; k++) begin
         tick;
         if (k == 1) chk("mid dropped din0", 32'(ia.din0), 32'd0);
         if (k == 2) chk("mid dropped din1", 32'(ia.din1), 32'd0);
      end
      rst = 0;
      tick;
      rst = 1;
      for (int c = 1; c <= 16; c++) begin
         tick;
         if (c == 15) chk("re init_done @15", 32'(ia.init_done), 32'd0);
         if (c == 16) chk("re init_done @16", 32'(ia.init_done), 32'd1);
         if (c == 11) chk("re o init_done @11", 32'(ob.init_done), 32'd0);
         if (c == 12) chk("re o init_done @12", 32'(ob.init_done), 32'd1);
      end
      dump_zero("reclear");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
